kb_matrix_gen: RTL and testbench

// - Parametrised keyboard-matrix emulator between a PS/2 scancode decoder and the machine's keyboard scan port.
// - Accepts key events (row, col, press/release) through a valid/ready handshake into an event FIFO.
// - Holds a ROWS x COLS active-low matrix and returns the selected row's columns.
// - ANDs in NUM_JOY joystick connectors on configurable rows.
// - Enforces a minimum press time so fast typing is never missed by a slow scanner.

---
 rtl/kb_matrix_gen.sv | 201 ++++++++++++++++++++
 tb/tb_kb_matrix_gen.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/kb_matrix_gen.sv
// rtl/kb_matrix_gen.sv - keyboard-matrix emulator fed by key events through a FIFO
//
// Purpose: keeps a ROWS x COLS active-low key matrix updated from (row, col,
// press/release) events queued in an event FIFO, returns the scanned row on
// columns, and ANDs joystick connectors onto their rows.
// Build option: define KBM_MIN_HOLD_EN to enforce MIN_HOLD clk cycles between
// an applied press and the next applied release (releases stall at the FIFO
// head); when undefined the FIFO pops every cycle it is non-empty.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   ev_valid/ready  key event handshake; ev_row, ev_col, ev_released = event
//   clear_all       pulse: release every key and flush the FIFO
//   rowselect       row being scanned; columns = that row, active low
//   joy             per connector {fire1,fire2,right,left,down,up}, active low
//   ev_drop         pulse: popped event was out of range and discarded
//   fifo_ovf        sticky: event offered while ev_ready was low
module kb_matrix_gen #(
  parameter int ROWS       = 10,
  parameter int COLS       = 8,
  parameter int ROWSEL_W   = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int MIN_HOLD   = 65536,
  parameter int NUM_JOY    = 1,
  parameter int JOY_ROW0   = 9,
  parameter int JOY_ROW1   = 6
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     ev_valid,
  output logic                                     ev_ready,
  input  logic [3:0]                               ev_row,
  input  logic [2:0]                               ev_col,
  input  logic                                     ev_released,
  input  logic                                     clear_all,
  input  logic [ROWSEL_W-1:0]                      rowselect,
  input  logic [((NUM_JOY > 0) ? 6*NUM_JOY : 1)-1:0] joy,
  output logic [COLS-1:0]                          columns,
  output logic                                     ev_drop,
  output logic                                     fifo_ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // Matrix storage: 1 = key up.
  logic [COLS-1:0] matrix_q [ROWS];
  logic [COLS-1:0] matrix_d [ROWS];

  // FIFO entries are {released, row[3:0], col[2:0]}.
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ev_drop_q, ev_drop_d;
  logic          fifo_ovf_q, fifo_ovf_d;

  logic       full, empty, push, pop, stall, hit;
  logic [7:0] head;

`ifdef KBM_MIN_HOLD_EN
  localparam int HW = $clog2(MIN_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MIN_HOLD);
  logic [HW-1:0] hold_q, hold_d;
`endif

  always_comb begin
    full     = (count_q == (AW+1)'(FIFO_DEPTH));
    empty    = (count_q == '0);
    ev_ready = !full && !clear_all && !rst;
    push     = ev_valid && ev_ready;
    head     = mem_q[rd_ptr_q];
`ifdef KBM_MIN_HOLD_EN
    // Only a release waits; presses always go straight through.
    stall    = head[7] && (hold_q != HOLD_MAX);
`else
    stall    = 1'b0;
`endif
    pop      = !empty && !stall && !clear_all;

    // Applying the head: a position match doubles as the range check.
    matrix_d = matrix_q;
    hit      = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (pop && head[6:3] == 4'(r) && head[2:0] == 3'(c)) begin
          matrix_d[r][c] = head[7];
          hit            = 1'b1;
        end
      end
    end
    ev_drop_d = pop && !hit;

`ifdef KBM_MIN_HOLD_EN
    if (pop && hit && !head[7])
      hold_d = '0;
    else if (hold_q != HOLD_MAX)
      hold_d = hold_q + 1'b1;
    else
      hold_d = hold_q;
`endif

    mem_d = mem_q;
    if (push)
      mem_d[wr_ptr_q] = {ev_released, ev_row, ev_col};
    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
    fifo_ovf_d = fifo_ovf_q | (ev_valid && !ev_ready);

    // clear_all overrides any push/pop decided above.
    if (clear_all) begin
      for (int r = 0; r < ROWS; r++)
        matrix_d[r] = '1;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      ev_drop_d  = 1'b0;
      fifo_ovf_d = 1'b0;
`ifdef KBM_MIN_HOLD_EN
      hold_d     = HOLD_MAX;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++)
        matrix_q[r] <= '1;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      ev_drop_q  <= 1'b0;
      fifo_ovf_q <= 1'b0;
`ifdef KBM_MIN_HOLD_EN
      hold_q     <= HOLD_MAX;
`endif
    end else begin
      matrix_q   <= matrix_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      ev_drop_q  <= ev_drop_d;
      fifo_ovf_q <= fifo_ovf_d;
`ifdef KBM_MIN_HOLD_EN
      hold_q     <= hold_d;
`endif
    end
  end

  // FIFO payload needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign ev_drop  = ev_drop_q;
  assign fifo_ovf = fifo_ovf_q;

  // Joystick masks, widened with 1s above the six switch bits.
  logic [COLS-1:0] jmask0, jmask1;
  logic            jsel0, jsel1;

  generate
    if (NUM_JOY >= 1) begin : g_joy0
      logic [7:0] m0;
      assign m0     = {2'b11, joy[5:0]};
      assign jmask0 = m0[COLS-1:0];
      assign jsel0  = (rowselect == ROWSEL_W'(JOY_ROW0));
    end else begin : g_nojoy0
      assign jmask0 = '1;
      assign jsel0  = 1'b0;
    end
    if (NUM_JOY >= 2) begin : g_joy1
      logic [7:0] m1;
      assign m1     = {2'b11, joy[11:6]};
      assign jmask1 = m1[COLS-1:0];
      assign jsel1  = (rowselect == ROWSEL_W'(JOY_ROW1));
    end else begin : g_nojoy1
      assign jmask1 = '1;
      assign jsel1  = 1'b0;
    end
  endgenerate

  logic in_rng;

  always_comb begin
    columns = '1;
    in_rng  = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      if (rowselect == ROWSEL_W'(r)) begin
        columns = matrix_q[r];
        in_rng  = 1'b1;
      end
    end
    // Unscanned rows stay all 1s even if a joystick row is set beyond ROWS.
    if (in_rng && jsel0)
      columns = columns & jmask0;
    if (in_rng && jsel1)
      columns = columns & jmask1;
  end

endmodule

// File: tb/tb_kb_matrix_gen.sv
// tb/tb_kb_matrix_gen.sv - self-checking bench for kb_matrix_gen
module tb_kb_matrix_gen;

  localparam int ROWS = 10;
  localparam int COLS = 8;
  localparam int DEPTH = 8;
  localparam int MIN_HOLD = 16;
`ifdef KBM_MIN_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
  localparam logic [7:0] R14 = 8'h7F;
  localparam int HOLD_EXP = 16;
`else
  localparam bit HOLD_EN = 1'b0;
  localparam logic [7:0] R14 = 8'hFF;
  localparam int HOLD_EXP = 1;
`endif

  logic       clk = 1'b0;
  logic       rst, ev_valid, ev_ready, ev_released, clear_all;
  logic [3:0] ev_row;
  logic [2:0] ev_col;
  logic [3:0] rowselect;
  logic [5:0] joy;
  logic [7:0] columns;
  logic       ev_drop, fifo_ovf;

  always #5 clk = ~clk;

  kb_matrix_gen #(
    .ROWS(ROWS), .COLS(COLS), .ROWSEL_W(4), .FIFO_DEPTH(DEPTH),
    .MIN_HOLD(MIN_HOLD), .NUM_JOY(1), .JOY_ROW0(9), .JOY_ROW1(6)
  ) dut (
    .clk(clk), .rst(rst), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_row(ev_row), .ev_col(ev_col), .ev_released(ev_released),
    .clear_all(clear_all), .rowselect(rowselect), .joy(joy),
    .columns(columns), .ev_drop(ev_drop), .fifo_ovf(fifo_ovf)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: key state, event queue, cycles since last applied press.
  typedef struct { bit rel; int row; int col; } ev_t;
  bit  key_up [ROWS][COLS];
  ev_t q[$];
  int  since;
  bit  m_drop, m_ovf;

  function automatic void model_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        key_up[r][c] = 1'b1;
    q.delete();
    since  = MIN_HOLD;
    m_drop = 1'b0;
    m_ovf  = 1'b0;
  endfunction

  function automatic void model_tick();
    bit  ready, papp;
    ev_t h;
    if (rst || clear_all) begin
      model_reset();
      return;
    end
    ready  = q.size() < DEPTH;
    m_drop = 1'b0;
    papp   = 1'b0;
    if (q.size() > 0) begin
      h = q[0];
      if (!(HOLD_EN && h.rel && since < MIN_HOLD)) begin
        h = q.pop_front();
        if (h.row < ROWS && h.col < COLS) begin
          key_up[h.row][h.col] = h.rel;
          papp = !h.rel;
        end else begin
          m_drop = 1'b1;
        end
      end
    end
    since = papp ? 0 : ((since < MIN_HOLD) ? since + 1 : MIN_HOLD);
    if (ev_valid && ready)
      q.push_back('{ev_released, int'(ev_row), int'(ev_col)});
    if (ev_valid && !ready)
      m_ovf = 1'b1;
  endfunction

  function automatic logic [7:0] model_cols(input int rs, input logic [5:0] j);
    logic [7:0] v;
    if (rs >= ROWS) return 8'hFF;
    for (int c = 0; c < COLS; c++)
      v[c] = key_up[rs][c];
    if (rs == 9)
      v = v & {2'b11, j};
    return v;
  endfunction

  task automatic drive(input bit r, input bit c, input bit v, input bit rel,
                       input int row, input int col, input int rs, input logic [5:0] j);
    rst = r; clear_all = c; ev_valid = v; ev_released = rel;
    ev_row = 4'(row); ev_col = 3'(col); rowselect = 4'(rs); joy = j;
  endtask

  logic [7:0] s_cols;
  logic       s_rdy, s_drop, s_ovf;

  // One clock: sample at negedge, optionally compare to model, advance model.
  task automatic step(input bit use_model);
    @(negedge clk);
    s_cols = columns; s_rdy = ev_ready; s_drop = ev_drop; s_ovf = fifo_ovf;
    if (use_model) begin
      chk("m_columns", s_cols, model_cols(int'(rowselect), joy));
      chk("m_ev_ready", s_rdy, !rst && !clear_all && (q.size() < DEPTH));
      chk("m_ev_drop", s_drop, m_drop);
      chk("m_fifo_ovf", s_ovf, m_ovf);
    end
    model_tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit rst, clr, vld, rel;
    int row, col, rs;
    logic [5:0] joy;
    logic [7:0] cols;
    bit rdy, drop, ovf;
  } vec_t;

  vec_t tbl[17];
  int low_cnt;

  initial begin
    tbl[0]  = '{1,0,0,0, 0,0, 0, 6'h3F, 8'hFF, 0,0,0};
    tbl[1]  = '{0,0,1,0, 8,7, 8, 6'h3F, 8'hFF, 1,0,0};
    tbl[2]  = '{0,0,0,0, 0,0, 8, 6'h3F, 8'hFF, 1,0,0};
    tbl[3]  = '{0,0,0,0, 0,0, 8, 6'h3F, 8'h7F, 1,0,0};
    tbl[4]  = '{0,0,0,0, 0,0, 7, 6'h3F, 8'hFF, 1,0,0};
    tbl[5]  = '{0,0,1,0,12,0, 8, 6'h3F, 8'h7F, 1,0,0};
    tbl[6]  = '{0,0,0,0, 0,0,15, 6'h3F, 8'hFF, 1,0,0};
    tbl[7]  = '{0,0,0,0, 0,0, 8, 6'h3F, 8'h7F, 1,1,0};
    tbl[8]  = '{0,0,0,0, 0,0, 8, 6'h3F, 8'h7F, 1,0,0};
    tbl[9]  = '{0,0,1,0, 9,7, 9, 6'h3F, 8'hFF, 1,0,0};
    tbl[10] = '{0,0,0,0, 0,0, 9, 6'h3E, 8'hFE, 1,0,0};
    tbl[11] = '{0,0,0,0, 0,0, 9, 6'h3E, 8'h7E, 1,0,0};
    tbl[12] = '{0,0,1,1, 8,7, 8, 6'h3F, 8'h7F, 1,0,0};
    tbl[13] = '{0,0,0,0, 0,0, 8, 6'h3F, 8'h7F, 1,0,0};
    tbl[14] = '{0,0,0,0, 0,0, 8, 6'h3F, R14,   1,0,0};
    tbl[15] = '{0,1,1,0, 2,5, 9, 6'h3F, 8'h7F, 0,0,0};
    tbl[16] = '{0,0,0,0, 0,0, 9, 6'h3F, 8'hFF, 1,0,0};

    // Initial reset edge before anything is observable.
    drive(1, 0, 0, 0, 0, 0, 0, 6'h3F);
    model_reset();
    @(posedge clk);
    #1;

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].rst, tbl[i].clr, tbl[i].vld, tbl[i].rel,
            tbl[i].row, tbl[i].col, tbl[i].rs, tbl[i].joy);
      @(negedge clk);
      chk($sformatf("t%0d_columns", i), columns, tbl[i].cols);
      chk($sformatf("t%0d_ev_ready", i), ev_ready, tbl[i].rdy);
      chk($sformatf("t%0d_ev_drop", i), ev_drop, tbl[i].drop);
      chk($sformatf("t%0d_fifo_ovf", i), fifo_ovf, tbl[i].ovf);
      model_tick();
      @(posedge clk);
      #1;
    end

    // Back-to-back press/release of (2,5): how long does the key read low?
    drive(0, 0, 1, 0, 2, 5, 2, 6'h3F);
    step(1);
    drive(0, 0, 1, 1, 2, 5, 2, 6'h3F);
    step(1);
    low_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      drive(0, 0, 0, 0, 0, 0, 2, 6'h3F);
      step(1);
      if (s_cols[5] == 1'b0)
        low_cnt++;
    end
    chk("hold_low_cycles", low_cnt, HOLD_EXP);

`ifdef KBM_MIN_HOLD_EN
    // Stalled release at the head lets the FIFO fill and overflow.
    drive(0, 0, 1, 0, 3, 3, 3, 6'h3F);
    step(1);
    drive(0, 0, 1, 1, 3, 3, 3, 6'h3F);
    step(1);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 1, 0, 4, i % 8, 4, 6'h3F);
      step(1);
    end
    drive(0, 0, 0, 0, 0, 0, 3, 6'h3F);
    step(1);
    chk("ovf_sticky", s_ovf, 1'b1);
    chk("ovf_ready_low", s_rdy, 1'b0);
    chk("ovf_matrix_kept", s_cols, 8'hF7);
    drive(0, 1, 0, 0, 0, 0, 3, 6'h3F);
    step(1);
    drive(0, 0, 0, 0, 0, 0, 3, 6'h3F);
    step(1);
    chk("clear_cols", s_cols, 8'hFF);
    chk("clear_ready", s_rdy, 1'b1);
    chk("clear_ovf", s_ovf, 1'b0);
`endif

    // Randomised traffic against the model.
    for (int i = 0; i < 800; i++) begin
      drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 59) == 0),
            $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 11), $urandom_range(0, 7),
            $urandom_range(0, 15), 6'($urandom));
      step(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
